// File: rtl/ili_cmd_seq_if.sv
// Bundle of the controller handshake, command-ROM port and ILI9341 8080-I write bus.
interface ili_cmd_seq_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 6
) ();
  logic          i_send_comm_ena;
  logic          i_command;
  logic          o_command_sent;
  logic          o_busy;
  logic [AW-1:0] o_rom_addr;
  logic [DW+1:0] i_rom_data;
  logic          o_lcd_csx;
  logic          o_lcd_dcx;
  logic          o_lcd_wrx;
  logic [DW-1:0] o_lcd_data;

  modport master (
    output i_send_comm_ena, i_command, i_rom_data,
    input  o_command_sent, o_busy, o_rom_addr,
    input  o_lcd_csx, o_lcd_dcx, o_lcd_wrx, o_lcd_data
  );

  modport slave (
    input  i_send_comm_ena, i_command, i_rom_data,
    output o_command_sent, o_busy, o_rom_addr,
    output o_lcd_csx, o_lcd_dcx, o_lcd_wrx, o_lcd_data
  );
endinterface

// File: rtl/ili_cmd_seq.sv
// ILI9341 command sequencer: walks an INIT or LOOP table in a sync ROM and
// replays it as 8080-I parallel writes, ms delays and table-complete signalling.
module ili_cmd_seq #(
  parameter int unsigned DW         = 8,
  parameter int unsigned AW         = 6,
  parameter int unsigned LOOP_BASE  = 32,
  parameter int unsigned WR_CYC     = 4,
  parameter int unsigned CYC_PER_MS = 100000
) (
  input  logic        clk,
  input  logic        rst,
  ili_cmd_seq_if.slave bus
);

  localparam int unsigned   CW        = 32;
  localparam logic [CW-1:0] WR_LAST   = CW'(WR_CYC - 1);
  localparam logic [CW-1:0] MS_CYC    = CW'(CYC_PER_MS);
  localparam logic [AW-1:0] INIT_ADDR = '0;
  localparam logic [AW-1:0] LOOP_ADDR = AW'(LOOP_BASE);
  localparam logic [AW-1:0] LAST_ADDR = '1;
  localparam logic [1:0]    T_DELAY   = 2'b10;
  localparam logic [1:0]    T_END     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ROMWAIT, S_DECODE, S_WR_LO, S_WR_HI, S_DELAY, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW:0]   ent_q, ent_d;
  logic          cmd_q, cmd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          step, fin, loop_end, can_abort;

  logic          csx_q, csx_d, wrx_q, wrx_d, dcx_q, dcx_d;
  logic [DW-1:0] data_q, data_d;
  logic          sent_q, sent_d, busy_q, busy_d;

  logic          ena, retarget;
  logic [AW-1:0] base_new;
  logic [1:0]    rom_type;
  logic [DW-1:0] rom_pay;

  assign ena      = bus.i_send_comm_ena;
  assign retarget = (bus.i_command != cmd_q);
  assign base_new = bus.i_command ? LOOP_ADDR : INIT_ADDR;
  assign rom_type = bus.i_rom_data[DW+1:DW];
  assign rom_pay  = bus.i_rom_data[DW-1:0];

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ent_q   <= '0;
      cmd_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ent_q   <= ent_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
    end
  end

  // Next state: table walk, then end-of-table handling, then abort/retarget
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ent_d    = ent_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    step     = 1'b0;
    fin      = 1'b0;
    loop_end = 1'b0;
    unique case (state_q)
      S_IDLE: if (ena) begin
        state_d = S_FETCH;
        addr_d  = base_new;
        cmd_d   = bus.i_command;
      end
      S_FETCH:   state_d = S_ROMWAIT;
      S_ROMWAIT: state_d = S_DECODE;
      S_DECODE: begin
        ent_d = bus.i_rom_data[DW:0];
        cnt_d = '0;
        if (rom_type == T_END) begin
          fin = 1'b1;
        end else if (rom_type == T_DELAY) begin
          if (rom_pay == '0) step = 1'b1;
          else begin
            state_d = S_DELAY;
            cnt_d   = CW'(rom_pay) * MS_CYC - CW'(1);
          end
        end else begin
          state_d = S_WR_LO;
        end
      end
      S_WR_LO: if (cnt_q == WR_LAST) begin
        state_d = S_WR_HI;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CW'(1);
      S_WR_HI: if (cnt_q == WR_LAST) step = 1'b1;
               else cnt_d = cnt_q + CW'(1);
      S_DELAY: if (cnt_q == '0) step = 1'b1;
               else cnt_d = cnt_q - CW'(1);
      S_DONE:  ;
      default: state_d = S_IDLE;
    endcase

    // The last ROM slot never wraps back to zero
    if (step) begin
      if (addr_q == LAST_ADDR) fin = 1'b1;
      else begin
        addr_d  = addr_q + AW'(1);
        state_d = S_FETCH;
      end
    end
    if (fin) begin
      if (cmd_q) begin
        loop_end = 1'b1;
        addr_d   = LOOP_ADDR;
        state_d  = S_FETCH;
      end else state_d = S_DONE;
    end

    // A started strobe always completes; everything else yields at once
    can_abort = (state_q inside {S_FETCH, S_ROMWAIT, S_DECODE, S_DELAY, S_DONE}) ||
                (state_q == S_WR_HI && cnt_q == WR_LAST);
    if (can_abort) begin
      if (!ena) begin
        state_d  = S_IDLE;
        loop_end = 1'b0;
      end else if (retarget) begin
        state_d  = S_FETCH;
        addr_d   = base_new;
        cmd_d    = bus.i_command;
        loop_end = 1'b0;
      end
    end
  end

  // Output next values: bus pins follow the current state one clock later
  always_comb begin
    csx_d  = csx_q;
    wrx_d  = 1'b1;
    dcx_d  = dcx_q;
    data_d = data_q;
    unique case (state_q)
      S_WR_LO: begin
        csx_d  = 1'b0;
        wrx_d  = 1'b0;
        dcx_d  = ent_q[DW];
        data_d = ent_q[DW-1:0];
      end
      S_DECODE:                  if (rom_type[1]) csx_d = 1'b1;
      S_IDLE, S_DELAY, S_DONE:   csx_d = 1'b1;
      default: ;
    endcase
    sent_d = (state_d == S_DONE) || loop_end;
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csx_q  <= 1'b1;
      wrx_q  <= 1'b1;
      dcx_q  <= 1'b1;
      data_q <= '0;
      sent_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      csx_q  <= csx_d;
      wrx_q  <= wrx_d;
      dcx_q  <= dcx_d;
      data_q <= data_d;
      sent_q <= sent_d;
      busy_q <= busy_d;
    end
  end

  assign bus.o_lcd_csx      = csx_q;
  assign bus.o_lcd_wrx      = wrx_q;
  assign bus.o_lcd_dcx      = dcx_q;
  assign bus.o_lcd_data     = data_q;
  assign bus.o_command_sent = sent_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_rom_addr     = addr_q;

endmodule

// File: tb/tb_ili_cmd_seq.sv
// Directed bench for ili_cmd_seq: INIT/LOOP tables, strobe timing, aborts and reset.
module tb_ili_cmd_seq;
  localparam int unsigned DW = 8, AW = 6, LOOP_BASE = 32, WR_CYC = 4, CYC_PER_MS = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ili_cmd_seq_if #(.DW(DW), .AW(AW)) bus ();

  ili_cmd_seq #(
    .DW(DW), .AW(AW), .LOOP_BASE(LOOP_BASE), .WR_CYC(WR_CYC), .CYC_PER_MS(CYC_PER_MS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DW+1:0] rom [0:(1<<AW)-1];
  always @(posedge clk) bus.i_rom_data <= rom[bus.o_rom_addr];

  // LCD latches on the rising strobe edge; a reset-forced rise is not a write
  logic [DW:0] wr_q[$];
  always @(posedge bus.o_lcd_wrx) if (rst) wr_q.push_back({bus.o_lcd_dcx, bus.o_lcd_data});

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [DW:0] wr_at(input int i);
    return (i < wr_q.size()) ? wr_q[i] : '1;
  endfunction

  task automatic wait_wr(input int n, input int limit);
    int k = 0;
    while (wr_q.size() < n && k < limit) begin nclk(1); k++; end
  endtask

  logic [11:0]   wv;
  logic [6:0]    wv4;
  logic [DW-1:0] d_lo, d_hi;
  logic          c_lo, prev;
  int            gap, n, pulses, hi;

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = {2'b11, 8'h00};
    rom[0]  = {2'b00, 8'h01};
    rom[1]  = {2'b10, 8'h05};
    rom[2]  = {2'b00, 8'h11};
    rom[3]  = {2'b01, 8'hA5};
    rom[4]  = {2'b11, 8'h00};
    rom[32] = {2'b00, 8'h2C};
    rom[33] = {2'b01, 8'hFF};
    rom[34] = {2'b11, 8'h00};
    bus.i_send_comm_ena = 1'b0;
    bus.i_command       = 1'b0;

    nclk(2);
    chk("rst_csx",  bus.o_lcd_csx, 1);
    chk("rst_wrx",  bus.o_lcd_wrx, 1);
    chk("rst_dcx",  bus.o_lcd_dcx, 1);
    chk("rst_data", bus.o_lcd_data, 0);
    chk("rst_addr", bus.o_rom_addr, 0);
    chk("rst_sent", bus.o_command_sent, 0);
    chk("rst_busy", bus.o_busy, 0);
    rst = 1'b1;
    nclk(2);

    // INIT table, first strobe shape and latency
    bus.i_send_comm_ena = 1'b1;
    for (int i = 0; i < 12; i++) begin
      nclk(1);
      wv[11-i] = bus.o_lcd_wrx;
      if (i == 4) begin d_lo = bus.o_lcd_data; c_lo = bus.o_lcd_csx; end
      if (i == 8) d_hi = bus.o_lcd_data;
    end
    chk("wrx_shape",   wv, 12'b1111_0000_1111);
    chk("wr1_data_lo", d_lo, 8'h01);
    chk("wr1_csx_lo",  c_lo, 0);
    chk("wr1_data_hi", d_hi, 8'h01);

    gap = 0; n = 0;
    while (!bus.o_command_sent && n < 500) begin
      nclk(1); n++;
      if (wr_q.size() == 1 && bus.o_lcd_csx) gap++;
    end
    chk("init_sent",  bus.o_command_sent, 1);
    chk("init_nwr",   wr_q.size(), 3);
    chk("init_wr0",   wr_at(0), {1'b0, 8'h01});
    chk("init_wr1",   wr_at(1), {1'b0, 8'h11});
    chk("init_wr2",   wr_at(2), {1'b1, 8'hA5});
    chk("delay_gap",  gap >= 50, 1);
    nclk(10);
    chk("done_sent_hold", bus.o_command_sent, 1);
    chk("done_busy",      bus.o_busy, 0);
    chk("done_csx",       bus.o_lcd_csx, 1);

    // Table switch while parked in DONE
    wr_q.delete();
    bus.i_command = 1'b1;
    nclk(1);
    chk("sw_sent_drop", bus.o_command_sent, 0);
    chk("sw_addr",      bus.o_rom_addr, LOOP_BASE);
    wait_wr(1, 100);
    chk("sw_first_wr",  wr_at(0), {1'b0, 8'h2C});
    bus.i_send_comm_ena = 1'b0;
    nclk(20);
    chk("sw_idle_busy", bus.o_busy, 0);

    // LOOP table, three passes
    wr_q.delete();
    bus.i_send_comm_ena = 1'b1;
    pulses = 0; hi = 0; prev = 1'b0; n = 0;
    while (pulses < 3 && n < 1000) begin
      nclk(1); n++;
      if (bus.o_command_sent) hi++;
      if (bus.o_command_sent && !prev) pulses++;
      prev = bus.o_command_sent;
    end
    chk("loop_pulses", pulses, 3);
    chk("loop_hi_cyc", hi, 3);
    chk("loop_addr",   bus.o_rom_addr, LOOP_BASE);
    bus.i_send_comm_ena = 1'b0;
    nclk(1);
    chk("loop_pulse_end", bus.o_command_sent, 0);
    nclk(20);
    chk("loop_nwr", wr_q.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("loop_wr%0d", i), wr_at(i), (i % 2 == 0) ? {1'b0, 8'h2C} : {1'b1, 8'hFF});

    // Enable dropped one clock into WR_LO
    wr_q.delete();
    bus.i_command       = 1'b0;
    bus.i_send_comm_ena = 1'b1;
    nclk(5);
    chk("drop_wrx_lo", bus.o_lcd_wrx, 0);
    bus.i_send_comm_ena = 1'b0;
    for (int i = 0; i < 7; i++) begin
      nclk(1);
      wv4[6-i] = bus.o_lcd_wrx;
    end
    chk("drop_strobe", wv4, 7'b000_1111);
    nclk(20);
    chk("drop_csx",  bus.o_lcd_csx, 1);
    chk("drop_busy", bus.o_busy, 0);
    chk("drop_nwr",  wr_q.size(), 1);
    chk("drop_wr0",  wr_at(0), {1'b0, 8'h01});

    // Asynchronous reset in the middle of WR_LO
    wr_q.delete();
    bus.i_send_comm_ena = 1'b1;
    nclk(6);
    chk("arst_pre_wrx", bus.o_lcd_wrx, 0);
    rst = 1'b0;
    bus.i_send_comm_ena = 1'b0;
    #1;
    chk("arst_wrx",  bus.o_lcd_wrx, 1);
    chk("arst_csx",  bus.o_lcd_csx, 1);
    chk("arst_data", bus.o_lcd_data, 0);
    chk("arst_busy", bus.o_busy, 0);
    nclk(1);
    rst = 1'b1;
    nclk(30);
    chk("arst_quiet_nwr",  wr_q.size(), 0);
    chk("arst_quiet_busy", bus.o_busy, 0);
    bus.i_send_comm_ena = 1'b1;
    wait_wr(1, 100);
    chk("arst_restart_wr", wr_at(0), {1'b0, 8'h01});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
